// File: rtl/expr_str_parser_if.sv
// expr_str_parser_if: character stream in, per-string verdict out
interface expr_str_parser_if #(
  parameter int HEX_MAX = 4,
  parameter int POS_W = 8
);
  logic in_valid;
  logic [7:0] in_char;
  logic done;
  logic ok;
  logic [4*HEX_MAX-1:0] op_a;
  logic [4*HEX_MAX-1:0] op_b;
  logic [2:0] op_code;
  logic [2:0] err_code;
  logic [POS_W-1:0] err_pos;
  logic busy;
  modport master(output in_valid, in_char, input done, ok, op_a, op_b, op_code, err_code, err_pos, busy);
  modport slave(input in_valid, in_char, output done, ok, op_a, op_b, op_code, err_code, err_pos, busy);
endinterface

// File: rtl/expr_str_parser.sv
// expr_str_parser: recognises OPEN hex op hex CLOSE strings framed by \0 and reports a verdict
module expr_str_parser #(
  parameter int HEX_MIN = 1,
  parameter int HEX_MAX = 4,
  parameter logic [7:0] OPEN_CH = 8'h7B,
  parameter logic [7:0] CLOSE_CH = 8'h7D,
  parameter int CASE_MODE = 0,
  parameter int POS_W = 8
) (
  input logic clk,
  input logic rst_n,
  expr_str_parser_if.slave bus
);
  localparam int W = 4 * HEX_MAX;
  localparam int NW = $clog2(HEX_MAX + 1);
  localparam logic [NW-1:0] N_MIN = NW'(HEX_MIN);
  localparam logic [NW-1:0] N_MAX = NW'(HEX_MAX);
  typedef enum logic [2:0] {IDLE, START, OPEN, DIG_A, OP, DIG_B, CLOSE, ERR} state_t;
  state_t st;
  logic [NW-1:0] n;
  logic [W-1:0] acc_a, acc_b;
  logic [2:0] opc, err, fault, opv;
  logic [POS_W-1:0] cnt, epos;
  logic [7:0] c;
  logic [3:0] nib;
  logic nul, dig, up, lo, hex, sym, busy;
  assign busy = st != IDLE && st != START;
  assign bus.busy = busy;
  // classify the incoming character and work out which error (if any) it raises in the current state
  always_comb begin
    c = bus.in_char;
    nul = c == 8'h00;
    dig = c >= 8'h30 && c <= 8'h39;
    up = c >= 8'h41 && c <= 8'h46 && CASE_MODE != 2;
    lo = c >= 8'h61 && c <= 8'h66 && CASE_MODE != 1;
    hex = dig || up || lo;
    nib = dig ? c[3:0] : c[3:0] + 4'd9;
    sym = c inside {8'h2B, 8'h2D, 8'h2A, 8'h2F, 8'h5C, 8'h3D, 8'h3C, 8'h3E};
    opv = c == 8'h2B ? 3'd0 : c == 8'h2D ? 3'd1 : c == 8'h2A ? 3'd2 : c == 8'h2F ? 3'd3 :
          c == 8'h5C ? 3'd4 : c == 8'h3D ? 3'd5 : c == 8'h3C ? 3'd6 : 3'd7;
    fault = (st == OPEN || st == OP) ? (hex ? 3'd0 : 3'd3) :
            (st == DIG_A || st == DIG_B) ?
              (hex ? (n == N_MAX ? 3'd2 : 3'd0) :
               (st == DIG_A ? sym : c == CLOSE_CH) ? (n < N_MIN ? 3'd2 : 3'd0) : 3'd3) :
            st == CLOSE ? 3'd4 : 3'd0;
  end
  // recognition FSM; a \0 in any busy state ends the string and publishes the verdict
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= IDLE;
      n <= '0;
      acc_a <= '0;
      acc_b <= '0;
      opc <= '0;
      err <= '0;
      cnt <= '0;
      epos <= '0;
      bus.done <= 1'b0;
      bus.ok <= 1'b0;
      bus.op_a <= '0;
      bus.op_b <= '0;
      bus.op_code <= '0;
      bus.err_code <= '0;
      bus.err_pos <= '0;
    end else begin
      bus.done <= 1'b0;
      if (bus.in_valid) begin
        cnt <= &cnt ? cnt : cnt + 1'b1;
        if (nul && busy) begin
          st <= START;
          bus.done <= 1'b1;
          bus.ok <= st == CLOSE;
          bus.op_a <= acc_a;
          bus.op_b <= acc_b;
          bus.op_code <= opc;
          bus.err_code <= st == CLOSE ? 3'd0 : st == ERR ? err : 3'd5;
          bus.err_pos <= st == CLOSE ? POS_W'(0) : st == ERR ? epos : cnt;
        end else if (fault != 3'd0) begin
          st <= ERR;
          err <= fault;
          epos <= cnt;
        end else begin
          case (st)
            IDLE: if (nul) st <= START;
            START: if (!nul) begin
              st <= c == OPEN_CH ? OPEN : ERR;
              err <= c == OPEN_CH ? 3'd0 : 3'd1;
              epos <= '0;
              cnt <= POS_W'(1);
              acc_a <= '0;
              acc_b <= '0;
              opc <= '0;
              n <= '0;
            end
            OPEN: begin
              st <= DIG_A;
              n <= NW'(1);
              acc_a <= W'(nib);
            end
            DIG_A: if (hex) begin
              acc_a <= (acc_a << 4) | W'(nib);
              n <= n + 1'b1;
            end else begin
              st <= OP;
              opc <= opv;
              acc_b <= '0;
            end
            OP: begin
              st <= DIG_B;
              n <= NW'(1);
              acc_b <= W'(nib);
            end
            DIG_B: if (hex) begin
              acc_b <= (acc_b << 4) | W'(nib);
              n <= n + 1'b1;
            end else st <= CLOSE;
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_expr_str_parser.sv
// tb_expr_str_parser: random and directed strings against a string-level verdict model
module tb_expr_str_parser;
  typedef logic [7:0] str_t[$];
  typedef struct {
    logic ok;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0] opc;
    logic [2:0] err;
    int pos;
  } verdict_t;

  logic clk = 0, rst_n = 0, in_valid = 0;
  logic [7:0] in_char = 0;
  int checks = 0, errors = 0;
  bit run = 0;
  bit idle = 1;
  bit exp_done = 0;
  str_t sbuf;
  verdict_t held[2];

  always #5 clk = ~clk;

  expr_str_parser_if #(.HEX_MAX(4), .POS_W(8)) b0 ();
  expr_str_parser_if #(.HEX_MAX(4), .POS_W(3)) b1 ();
  assign b0.in_valid = in_valid;
  assign b0.in_char = in_char;
  assign b1.in_valid = in_valid;
  assign b1.in_char = in_char;

  expr_str_parser d0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  expr_str_parser #(.HEX_MIN(2), .CASE_MODE(1), .POS_W(3)) d1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  function automatic int hexval(logic [7:0] c, int cm);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (cm != 2 && c >= "A" && c <= "F") return int'(c) - 55;
    if (cm != 1 && c >= "a" && c <= "f") return int'(c) - 87;
    return -1;
  endfunction

  function automatic int opval(logic [7:0] c);
    string ops = "+-*/\\=<>";
    for (int i = 0; i < 8; i++) if (c == ops[i]) return i;
    return -1;
  endfunction

  function automatic verdict_t zero_v();
    verdict_t v;
    v.ok = 0; v.a = 0; v.b = 0; v.opc = 0; v.err = 0; v.pos = 0;
    return v;
  endfunction

  // Parse a whole string (without its \0) and return the verdict it must produce.
  function automatic verdict_t judge(input str_t s, input int hmin, input int hmax, input int cm, input int posw);
    verdict_t v = zero_v();
    int i = 1, k, p = 0, len = s.size();
    logic [31:0] val;
    bit fin = 0;
    if (s[0] != 8'h7B) begin v.err = 1; fin = 1; end
    for (int o = 0; o < 2 && !fin; o++) begin
      val = 0;
      k = 0;
      while (i + k < len && hexval(s[i+k], cm) >= 0) begin
        if (k < hmax) val = (val << 4) | 32'(hexval(s[i+k], cm));
        k++;
      end
      if (o == 0) v.a = val; else v.b = val;
      fin = 1;
      if (k > hmax) begin v.err = 2; p = i + hmax; end
      else if (i + k == len) begin v.err = 5; p = len; end
      else if (k == 0) begin v.err = 3; p = i; end
      else if (o == 0 ? opval(s[i+k]) >= 0 : s[i+k] == 8'h7D) begin
        if (k < hmin) begin v.err = 2; p = i + k; end
        else if (o == 0) begin v.opc = 3'(opval(s[i+k])); i = i + k + 1; fin = 0; end
        else if (i + k + 1 < len) begin v.err = 4; p = i + k + 1; end
        else v.ok = 1;
      end else begin v.err = 3; p = i + k; end
    end
    v.pos = p > (1 << posw) - 1 ? (1 << posw) - 1 : p;
    return v;
  endfunction

  function automatic str_t to_q(string s);
    str_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic str_t gen();
    str_t s;
    string hx = "0123456789ABCDEFabcdef";
    string ops = "+-*/\\=<>";
    s.push_back($urandom_range(0, 9) == 0 ? 8'($urandom_range(1, 255)) : 8'h7B);
    repeat ($urandom_range(0, 5)) s.push_back(hx[$urandom_range(0, 21)]);
    s.push_back($urandom_range(0, 9) == 0 ? 8'h7D : ops[$urandom_range(0, 7)]);
    repeat ($urandom_range(0, 5)) s.push_back(hx[$urandom_range(0, 21)]);
    if ($urandom_range(0, 9) != 0) s.push_back(8'h7D);
    if ($urandom_range(0, 9) == 0) s.push_back(8'($urandom_range(1, 255)));
    if ($urandom_range(0, 7) == 0) s[$urandom_range(0, s.size() - 1)] = 8'($urandom_range(1, 255));
    if ($urandom_range(0, 6) == 0) repeat ($urandom_range(0, s.size() - 1)) s.delete(s.size() - 1);
    return s;
  endfunction

  task automatic pin(string name, verdict_t v, logic ok, logic [31:0] a, logic [31:0] b,
                     logic [2:0] opc, logic [2:0] err, int pos);
    checks++;
    if (v.ok !== ok || v.a !== a || v.b !== b || v.opc !== opc || v.err !== err || v.pos != pos) begin
      errors++;
      $display("FAIL pin %s got ok=%0d a=%h b=%h op=%0d err=%0d pos=%0d want ok=%0d a=%h b=%h op=%0d err=%0d pos=%0d",
               name, v.ok, v.a, v.b, v.opc, v.err, v.pos, ok, a, b, opc, err, pos);
    end
  endtask

  task automatic chk(string name, int k, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h at %0t", name, k, got, exp, $time);
    end
  endtask

  task automatic send(input logic [7:0] c, input int gap);
    @(negedge clk);
    in_valid = 1;
    in_char = c;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 0;
      in_char = 8'($urandom);
    end
  endtask

  task automatic send_s(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send(s[i], gap);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 0;
    in_valid = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  // Reference: framing by \0 at string level, verdict computed for each configuration.
  always @(posedge clk) begin
    exp_done = 0;
    if (!rst_n) begin
      idle = 1;
      sbuf.delete();
      held[0] = zero_v();
      held[1] = zero_v();
    end else if (in_valid) begin
      if (in_char == 8'h00) begin
        if (idle) idle = 0;
        else if (sbuf.size() > 0) begin
          exp_done = 1;
          held[0] = judge(sbuf, 1, 4, 0, 8);
          held[1] = judge(sbuf, 2, 4, 1, 3);
          sbuf.delete();
        end
      end else if (!idle) sbuf.push_back(in_char);
    end
  end

  // Compare every output of both instances each cycle.
  always @(negedge clk) begin
    if (run) begin
      chk("done", 0, 32'(b0.done), 32'(exp_done));
      chk("busy", 0, 32'(b0.busy), 32'(!idle && sbuf.size() > 0));
      chk("ok", 0, 32'(b0.ok), 32'(held[0].ok));
      chk("op_a", 0, 32'(b0.op_a), held[0].a);
      chk("op_b", 0, 32'(b0.op_b), held[0].b);
      chk("op_code", 0, 32'(b0.op_code), 32'(held[0].opc));
      chk("err_code", 0, 32'(b0.err_code), 32'(held[0].err));
      chk("err_pos", 0, 32'(b0.err_pos), 32'(held[0].pos));
      chk("done", 1, 32'(b1.done), 32'(exp_done));
      chk("busy", 1, 32'(b1.busy), 32'(!idle && sbuf.size() > 0));
      chk("ok", 1, 32'(b1.ok), 32'(held[1].ok));
      chk("op_a", 1, 32'(b1.op_a), held[1].a);
      chk("op_b", 1, 32'(b1.op_b), held[1].b);
      chk("op_code", 1, 32'(b1.op_code), 32'(held[1].opc));
      chk("err_code", 1, 32'(b1.err_code), 32'(held[1].err));
      chk("err_pos", 1, 32'(b1.err_pos), 32'(held[1].pos));
    end
  end

  initial begin
    pin("valid", judge(to_q("{1A2F+00b3}"), 1, 4, 0, 8), 1, 32'h1A2F, 32'h00B3, 0, 0, 0);
    pin("len", judge(to_q("{12345-1}"), 1, 4, 0, 8), 0, 32'h1234, 0, 0, 2, 5);
    pin("trunc", judge(to_q("{12*3"), 1, 4, 0, 8), 0, 32'h12, 32'h3, 2, 5, 5);
    pin("eq", judge(to_q("{1=2}"), 1, 4, 0, 8), 1, 32'h1, 32'h2, 5, 0, 0);
    pin("bad_open", judge(to_q("(1+2}"), 1, 4, 0, 8), 0, 0, 0, 0, 1, 0);
    pin("trail", judge(to_q("{1+2}x"), 1, 4, 0, 8), 0, 32'h1, 32'h2, 0, 4, 5);
    pin("case", judge(to_q("{ab+CD}"), 2, 4, 1, 8), 0, 0, 0, 0, 3, 1);
    pin("min", judge(to_q("{AB+C}"), 2, 4, 1, 8), 0, 32'hAB, 32'hC, 0, 2, 5);
    pin("ok_up", judge(to_q("{AB+CD}"), 2, 4, 1, 8), 1, 32'hAB, 32'hCD, 0, 0, 0);
    pin("sat", judge(to_q("{AB+CDEF1}"), 2, 4, 1, 3), 0, 32'hAB, 32'hCDEF, 0, 2, 7);
    repeat (3) @(negedge clk);
    rst_n = 1;
    run = 1;
    for (int g = 0; g < 4; g += 3) begin
      send(0, g); send_s("{1A2F+00b3}", g); send(0, g);
      send(0, g); send_s("{12345-1}", g); send(0, g);
      send(0, g); send_s("{12*3", g); send(0, g); send_s("{1=2}", g); send(0, g);
      send(0, g); send_s("(1+2}", g); send(0, g); send(0, g); send_s("{1+2}x", g); send(0, g);
      send(0, g); send_s("{ab+CD}", g); send(0, g); send_s("{AB+C}", g); send(0, g);
      send_s("{AB+CD}", g); send(0, g); send_s("{AB+CDEF1}", g); send(0, g);
      send(0, g); send_s("{1", g); apply_reset();
      send_s("{2+3}", g); send(0, g); send_s("{4+5}", g); send(0, g);
    end
    for (int t = 0; t < 400; t++) begin
      str_t s = gen();
      int g = $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0;
      if ($urandom_range(0, 49) == 0) apply_reset();
      if ($urandom_range(0, 9) == 0) send(8'($urandom), g);
      foreach (s[i]) send(s[i], g);
      send(0, g);
      if ($urandom_range(0, 4) == 0) send(0, g);
    end
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
